// File: rtl/uart_instr_loader_pkg.sv
// Shared definitions for the UART instruction loader.
//   rx_state_e    : receiver state encoding used by uart_rx_core
//   Parity*       : parity mode constants (none / even / odd)
//   clks_per_bit(): clock cycles per UART bit, rounded down
package uart_instr_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } rx_state_e;

  localparam int unsigned ParityNone = 0;
  localparam int unsigned ParityEven = 1;
  localparam int unsigned ParityOdd  = 2;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq_hz,
                                               input int unsigned baud);
    return clk_freq_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// UART byte receiver: 2-flop synchroniser, start-glitch rejection, 8 data bits LSB first,
// optional parity, stop-bit check and line-break wait.
//   clk, rst_n     : clock, asynchronous active-low reset
//   rx_i           : raw UART line (asynchronous, idle high)
//   enable_i       : low aborts any byte in progress and holds the receiver idle
//   start_ok_i     : permits a new start bit to be accepted
//   byte_o         : last good byte
//   byte_valid_o   : one-cycle pulse, byte_o holds a good byte
//   byte_err_o     : one-cycle pulse, byte dropped (parity or framing)
//   busy_o         : receiver is not in IDLE
module uart_rx_core
  import uart_instr_loader_pkg::*;
#(
  parameter int unsigned ClksPerBit = 868,
  parameter int unsigned Parity     = ParityNone
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  input  logic       enable_i,
  input  logic       start_ok_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       byte_err_o,
  output logic       busy_o
);

  localparam int unsigned CntW = $clog2(ClksPerBit + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2 - 1);

  rx_state_e       state_q;
  logic            rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            par_bad_q;
  logic [7:0]      byte_q;
  logic            byte_valid_q, byte_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_prev_q    <= 1'b1;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      byte_q       <= '0;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
    end else begin
      rx_meta_q    <= rx_i;
      rx_sync_q    <= rx_meta_q;
      rx_prev_q    <= rx_sync_q;
      byte_valid_q <= 1'b0;
      byte_err_q   <= 1'b0;
      if (!enable_i) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            if (start_ok_i && rx_prev_q && !rx_sync_q) begin
              state_q <= StStart;
              cnt_q   <= '0;
            end
          end
          StStart: begin
            if (cnt_q == HalfCnt) begin
              cnt_q <= '0;
              // High at the start-bit midpoint: treat as a glitch, no error.
              if (rx_sync_q) begin
                state_q <= StIdle;
              end else begin
                state_q   <= StData;
                bit_idx_q <= '0;
                par_bad_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StData: begin
            if (cnt_q == LastCnt) begin
              cnt_q     <= '0;
              shift_q   <= {rx_sync_q, shift_q[7:1]};
              bit_idx_q <= bit_idx_q + 1'b1;
              if (bit_idx_q == 3'd7) begin
                state_q <= (Parity != ParityNone) ? StParity : StStop;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StParity: begin
            if (cnt_q == LastCnt) begin
              cnt_q     <= '0;
              par_bad_q <= (^shift_q) ^ rx_sync_q ^ (Parity == ParityOdd);
              state_q   <= StStop;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StStop: begin
            if (cnt_q == LastCnt) begin
              cnt_q <= '0;
              if (!rx_sync_q) begin
                byte_err_q <= 1'b1;
                state_q    <= StWaitHigh;
              end else begin
                state_q <= StIdle;
                if (par_bad_q) begin
                  byte_err_q <= 1'b1;
                end else begin
                  byte_valid_q <= 1'b1;
                  byte_q       <= shift_q;
                end
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          StWaitHigh: begin
            if (rx_sync_q) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign byte_err_o   = byte_err_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: rtl/uart_instr_loader.sv
// Loads instruction words received over UART into an instruction memory.
// Bytes are assembled big-endian into words and written to consecutive addresses from
// START_ADDR; a quiet line for IDLE_TIMEOUT_BITS bit-periods after a write ends the transfer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_rx            : UART line (asynchronous, idle high)
//   i_enable        : load enable; low holds the receiver idle and drops a partial word
//   o_wr_en         : one-cycle write strobe, with o_wr_addr / o_wr_data
//   o_max_addr      : last address written
//   o_transmit_done : sticky, transfer complete
//   o_frame_err     : sticky framing / parity / partial-word error
//   o_overflow      : sticky, a word was dropped past the top of the address space
//   o_busy          : byte or partial word in progress
module uart_instr_loader
  import uart_instr_loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ       = 100000000,
  parameter int unsigned BAUD              = 115200,
  parameter int unsigned BYTES_PER_WORD    = 2,
  parameter int unsigned ADDR_WIDTH        = 8,
  parameter int unsigned START_ADDR        = 1,
  parameter int unsigned PARITY            = 0,
  parameter int unsigned IDLE_TIMEOUT_BITS = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_rx,
  input  logic                        i_enable,
  output logic                        o_wr_en,
  output logic [ADDR_WIDTH-1:0]       o_wr_addr,
  output logic [8*BYTES_PER_WORD-1:0] o_wr_data,
  output logic [ADDR_WIDTH-1:0]       o_max_addr,
  output logic                        o_transmit_done,
  output logic                        o_frame_err,
  output logic                        o_overflow,
  output logic                        o_busy
);

  localparam int unsigned ClksPerBit = clks_per_bit(CLK_FREQ_HZ, BAUD);
  localparam int unsigned WordW      = 8 * BYTES_PER_WORD;
  localparam int unsigned TickW      = $clog2(ClksPerBit + 1);
  localparam int unsigned IdleW      = $clog2(IDLE_TIMEOUT_BITS + 1);
  localparam logic [TickW-1:0]      TickLast  = TickW'(ClksPerBit - 1);
  localparam logic [IdleW-1:0]      IdleLast  = IdleW'(IDLE_TIMEOUT_BITS - 1);
  localparam logic [IdleW-1:0]      IdleMax   = IdleW'(IDLE_TIMEOUT_BITS);
  localparam logic [1:0]            LastByte  = 2'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_WIDTH-1:0] StartAddr = ADDR_WIDTH'(START_ADDR);

  logic [7:0] rx_byte;
  logic       rx_valid, rx_err, rx_busy;

  logic [1:0]            byte_cnt_q;
  logic [WordW-1:0]      word_q, word_next;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic                  addr_full_q, written_q;
  logic [TickW-1:0]      tick_q;
  logic [IdleW-1:0]      idle_bits_q;
  logic                  idle_hit;

  logic                  wr_en_q, done_q, frame_err_q, overflow_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, max_addr_q;
  logic [WordW-1:0]      wr_data_q;

  uart_rx_core #(
    .ClksPerBit(ClksPerBit),
    .Parity    (PARITY)
  ) u_rx (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_i        (i_rx),
    .enable_i    (i_enable),
    .start_ok_i  (!done_q),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_valid),
    .byte_err_o  (rx_err),
    .busy_o      (rx_busy)
  );

  // First byte ends up in the top byte once the word is complete.
  assign word_next = (word_q << 8) | WordW'(rx_byte);
  assign idle_hit  = !rx_busy && (tick_q == TickLast) && (idle_bits_q == IdleLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q  <= '0;
      word_q      <= '0;
      next_addr_q <= StartAddr;
      addr_full_q <= 1'b0;
      written_q   <= 1'b0;
      tick_q      <= '0;
      idle_bits_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      max_addr_q  <= '0;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;

      // Idle counter in bit-periods; saturates so the timeout fires once per quiet spell.
      if (rx_busy) begin
        tick_q      <= '0;
        idle_bits_q <= '0;
      end else if (idle_bits_q != IdleMax) begin
        if (tick_q == TickLast) begin
          tick_q      <= '0;
          idle_bits_q <= idle_bits_q + 1'b1;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end

      if (idle_hit) begin
        if (written_q) done_q <= 1'b1;
        if (byte_cnt_q != '0) begin
          frame_err_q <= 1'b1;
          byte_cnt_q  <= '0;
        end
      end

      if (rx_err) frame_err_q <= 1'b1;

      if (!i_enable) begin
        byte_cnt_q <= '0;
      end else if (rx_valid) begin
        word_q <= word_next;
        if (byte_cnt_q == LastByte) begin
          byte_cnt_q <= '0;
          if (addr_full_q) begin
            overflow_q <= 1'b1;
          end else begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= next_addr_q;
            wr_data_q  <= word_next;
            max_addr_q <= next_addr_q;
            written_q  <= 1'b1;
            if (next_addr_q == '1) addr_full_q <= 1'b1;
            else                   next_addr_q <= next_addr_q + 1'b1;
          end
        end else begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
      end
    end
  end

  assign o_wr_en         = wr_en_q;
  assign o_wr_addr       = wr_addr_q;
  assign o_wr_data       = wr_data_q;
  assign o_max_addr      = max_addr_q;
  assign o_transmit_done = done_q;
  assign o_frame_err     = frame_err_q;
  assign o_overflow      = overflow_q;
  assign o_busy          = rx_busy | (byte_cnt_q != '0);

endmodule

// File: tb/tb_uart_instr_loader.sv
module tb_uart_instr_loader;

  localparam int BitClks = 16;  // 1.6 MHz / 100 kbaud

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b1;
  logic rx_line [3];

  always #5 clk = ~clk;

  // A: default shape, B: 2-bit address space, C: even parity
  logic        wr_en_a, done_a, err_a, ovf_a, busy_a;
  logic [7:0]  wr_addr_a, max_a;
  logic [15:0] wr_data_a;
  logic        wr_en_b, done_b, err_b, ovf_b, busy_b;
  logic [1:0]  wr_addr_b, max_b;
  logic [15:0] wr_data_b;
  logic        wr_en_c, done_c, err_c, ovf_c, busy_c;
  logic [7:0]  wr_addr_c, max_c;
  logic [15:0] wr_data_c;

  uart_instr_loader #(.CLK_FREQ_HZ(1600000), .BAUD(100000)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_rx(rx_line[0]), .i_enable(enable),
    .o_wr_en(wr_en_a), .o_wr_addr(wr_addr_a), .o_wr_data(wr_data_a), .o_max_addr(max_a),
    .o_transmit_done(done_a), .o_frame_err(err_a), .o_overflow(ovf_a), .o_busy(busy_a)
  );

  uart_instr_loader #(.CLK_FREQ_HZ(1600000), .BAUD(100000), .ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_rx(rx_line[1]), .i_enable(enable),
    .o_wr_en(wr_en_b), .o_wr_addr(wr_addr_b), .o_wr_data(wr_data_b), .o_max_addr(max_b),
    .o_transmit_done(done_b), .o_frame_err(err_b), .o_overflow(ovf_b), .o_busy(busy_b)
  );

  uart_instr_loader #(.CLK_FREQ_HZ(1600000), .BAUD(100000), .PARITY(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_rx(rx_line[2]), .i_enable(enable),
    .o_wr_en(wr_en_c), .o_wr_addr(wr_addr_c), .o_wr_data(wr_data_c), .o_max_addr(max_c),
    .o_transmit_done(done_c), .o_frame_err(err_c), .o_overflow(ovf_c), .o_busy(busy_c)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  logic [23:0] wq_a[$], wq_b[$], wq_c[$], expq[$];
  logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Write recorders; also check each strobe lasts exactly one cycle.
  always @(negedge clk) begin
    if (wr_en_a) begin
      wq_a.push_back({wr_addr_a, wr_data_a});
      last_wr_cyc = cyc;
      check("pulse_a", {31'd0, prev_a}, 32'd0);
    end
    if (wr_en_b) begin
      wq_b.push_back({6'd0, wr_addr_b, wr_data_b});
      check("pulse_b", {31'd0, prev_b}, 32'd0);
    end
    if (wr_en_c) begin
      wq_c.push_back({wr_addr_c, wr_data_c});
      check("pulse_c", {31'd0, prev_c}, 32'd0);
    end
    prev_a = wr_en_a;
    prev_b = wr_en_b;
    prev_c = wr_en_c;
  end

  task automatic bits(input int n);
    repeat (n * BitClks) @(negedge clk);
  endtask

  // par < 0: no parity bit, otherwise par[0] is sent as the parity bit
  task automatic send_byte(input int ch, input logic [7:0] b, input logic stop_bit, input int par);
    rx_line[ch] = 1'b0;
    bits(1);
    for (int i = 0; i < 8; i++) begin
      rx_line[ch] = b[i];
      bits(1);
    end
    if (par >= 0) begin
      rx_line[ch] = par[0];
      bits(1);
    end
    rx_line[ch] = stop_bit;
    bits(1);
    rx_line[ch] = 1'b1;
    bits(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wq_a.delete();
    wq_b.delete();
    wq_c.delete();
    expq.delete();
  endtask

  task automatic wait_done_a(output int elapsed);
    elapsed = 0;
    while (!done_a && elapsed < 64 * BitClks) begin
      @(negedge clk);
      elapsed++;
    end
    check("done_a", {31'd0, done_a}, 32'd1);
  endtask

  // Compares one recorded queue against expq.
  task automatic check_writes(input string tag, input int ch);
    logic [23:0] got[$];
    case (ch)
      0:       got = wq_a;
      1:       got = wq_b;
      default: got = wq_c;
    endcase
    check({tag, "_count"}, got.size(), expq.size());
    for (int i = 0; i < expq.size() && i < got.size(); i++) check(tag, got[i], expq[i]);
  endtask

  initial begin
    int n, el, diff;
    logic [15:0] w;
    for (int i = 0; i < 3; i++) rx_line[i] = 1'b1;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_wr_en", {31'd0, wr_en_a}, 0);
    check("rst_wr_addr", {24'd0, wr_addr_a}, 0);
    check("rst_wr_data", {16'd0, wr_data_a}, 0);
    check("rst_max", {24'd0, max_a}, 0);
    check("rst_flags", {28'd0, done_a, err_a, ovf_a, busy_a}, 0);
    do_reset();

    // Two-word transfer and timeout
    send_byte(0, 8'h41, 1'b1, -1);
    send_byte(0, 8'h26, 1'b1, -1);
    send_byte(0, 8'h81, 1'b1, -1);
    send_byte(0, 8'h80, 1'b1, -1);
    expq = '{{8'd1, 16'h4126}, {8'd2, 16'h8180}};
    wait_done_a(el);
    diff = last_wr_cyc == 0 ? 0 : cyc - last_wr_cyc;
    check("done_delay_in_range", {31'd0, diff >= 30 * BitClks && diff <= 34 * BitClks}, 1);
    check_writes("basic", 0);
    check("basic_max", {24'd0, max_a}, 2);
    check("basic_err", {31'd0, err_a}, 0);
    // Activity after done is ignored
    send_byte(0, 8'h12, 1'b1, -1);
    send_byte(0, 8'h34, 1'b1, -1);
    check_writes("after_done", 0);
    check("after_done_busy", {31'd0, busy_a}, 0);

    // Randomized words against a simple address/data model
    for (int rep = 0; rep < 2; rep++) begin
      do_reset();
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) begin
        w = 16'($urandom);
        expq.push_back({8'(1 + i), w});
        send_byte(0, w[15:8], 1'b1, -1);
        send_byte(0, w[7:0], 1'b1, -1);
      end
      wait_done_a(el);
      check_writes("rand", 0);
      check("rand_max", {24'd0, max_a}, 32'(n));
      check("rand_err", {31'd0, err_a}, 0);
    end

    // Stop-bit error, then a good word
    do_reset();
    send_byte(0, 8'h41, 1'b0, -1);
    send_byte(0, 8'h41, 1'b1, -1);
    send_byte(0, 8'h00, 1'b1, -1);
    expq = '{{8'd1, 16'h4100}};
    wait_done_a(el);
    check("stop_err", {31'd0, err_a}, 1);
    check_writes("stop_err_wr", 0);

    // 0.3-bit glitch, then no timeout without a write
    do_reset();
    rx_line[0] = 1'b0;
    repeat (5) @(negedge clk);
    rx_line[0] = 1'b1;
    bits(4);
    check("glitch_busy", {31'd0, busy_a}, 0);
    check("glitch_err", {31'd0, err_a}, 0);
    check_writes("glitch_wr", 0);
    bits(40);
    check("no_word_no_done", {31'd0, done_a}, 0);

    // Partial word at timeout
    do_reset();
    send_byte(0, 8'h41, 1'b1, -1);
    send_byte(0, 8'h26, 1'b1, -1);
    send_byte(0, 8'h99, 1'b1, -1);
    expq = '{{8'd1, 16'h4126}};
    wait_done_a(el);
    check("partial_err", {31'd0, err_a}, 1);
    check_writes("partial_wr", 0);

    // Enable dropped mid-byte
    do_reset();
    send_byte(0, 8'h77, 1'b1, -1);
    rx_line[0] = 1'b0;
    bits(3);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_busy", {31'd0, busy_a}, 0);
    rx_line[0] = 1'b1;
    enable = 1'b1;
    bits(2);
    send_byte(0, 8'h12, 1'b1, -1);
    send_byte(0, 8'h34, 1'b1, -1);
    expq = '{{8'd1, 16'h1234}};
    wait_done_a(el);
    check_writes("abort_wr", 0);
    check("abort_err", {31'd0, err_a}, 0);

    // Reset after one byte discards it
    do_reset();
    send_byte(0, 8'h55, 1'b1, -1);
    do_reset();
    send_byte(0, 8'h41, 1'b1, -1);
    send_byte(0, 8'h00, 1'b1, -1);
    expq = '{{8'd1, 16'h4100}};
    wait_done_a(el);
    check_writes("midreset_wr", 0);
    check("midreset_err", {31'd0, err_a}, 0);

    // Address space exhaustion on B: only addresses 1..3 exist after START_ADDR
    do_reset();
    for (int i = 0; i < 4; i++) begin
      w = 16'($urandom);
      if (i < 3) expq.push_back({8'(1 + i), w});
      send_byte(1, w[15:8], 1'b1, -1);
      send_byte(1, w[7:0], 1'b1, -1);
    end
    bits(2);
    check_writes("ovf_wr", 1);
    check("ovf_flag", {31'd0, ovf_b}, 1);
    check("ovf_max", {30'd0, max_b}, 3);

    // Even parity on C
    do_reset();
    send_byte(2, 8'h03, 1'b1, 1);
    check("par_err", {31'd0, err_c}, 1);
    check("par_busy", {31'd0, busy_c}, 0);
    send_byte(2, 8'h41, 1'b1, 0);
    send_byte(2, 8'h00, 1'b1, 0);
    bits(2);
    expq = '{{8'd1, 16'h4100}};
    check_writes("par_wr", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
